// File: rtl/br_lite_ni_if.sv
// Four-phase flit link between the network interface and the router local port.
// The master drives flit/req and waits for ack; the slave answers with ack.
interface br_lite_ni_if #(
  parameter int unsigned FlitW = 73
) ();
  logic [FlitW-1:0] flit;
  logic             req;
  logic             ack;

  modport master (output flit, output req, input ack);
  modport slave  (input flit, input req, output ack);
endinterface

// File: rtl/br_lite_ni.sv
// Lite network interface: turns PE send requests into four-phase injections toward the router,
// and buffers delivered flits in a first-word-fall-through receive FIFO.
module br_lite_ni #(
  parameter logic [15:0] ADDRESS  = 16'h0000,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  input  logic        tx_tgt_i,
  input  logic [15:0] tx_target_i,
  input  logic [31:0] tx_payload_i,
  output logic [7:0]  tx_id_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic [72:0] rx_flit_o,
  input  logic        local_busy_i,
  br_lite_ni_if.master inj,
  br_lite_ni_if.slave  dlv
);

  typedef struct packed {
    logic [15:0] source;
    logic [15:0] target;
    logic        service;
    logic [7:0]  id;
    logic [31:0] payload;
  } br_data_t;

  localparam logic BR_SVC_ALL = 1'b0;
  localparam logic BR_SVC_TGT = 1'b1;

  localparam logic [1:0] TX_IDLE      = 2'd0;
  localparam logic [1:0] TX_WAIT_FREE = 2'd1;
  localparam logic [1:0] TX_REQ       = 2'd2;
  localparam logic [1:0] TX_RELEASE   = 2'd3;

  localparam logic RX_IDLE = 1'b0;
  localparam logic RX_ACK  = 1'b1;

  localparam int unsigned AW = $clog2(RX_DEPTH);
  localparam logic [AW:0] PtrOne = 1;

  // ---------------- transmit ----------------
  logic [1:0] tx_state_q;
  br_data_t   tx_flit_q;
  logic [7:0] id_cnt_q;
  logic [7:0] tx_id_q;
  logic       tx_accept;

  assign tx_ready_o = (tx_state_q == TX_IDLE);
  assign tx_accept  = tx_valid_i && tx_ready_o;
  assign inj.req    = (tx_state_q == TX_REQ);
  assign inj.flit   = tx_flit_q;
  assign tx_id_o    = tx_id_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tx_state_q <= TX_IDLE;
      tx_flit_q  <= '0;
      id_cnt_q   <= '0;
      tx_id_q    <= '0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_accept) begin
            tx_flit_q.source  <= ADDRESS;
            tx_flit_q.target  <= tx_tgt_i ? tx_target_i : 16'h0000;
            tx_flit_q.service <= tx_tgt_i ? BR_SVC_TGT : BR_SVC_ALL;
            tx_flit_q.id      <= id_cnt_q;
            tx_flit_q.payload <= tx_payload_i;
            tx_id_q           <= id_cnt_q;
            id_cnt_q          <= id_cnt_q + 8'd1;
            tx_state_q        <= TX_WAIT_FREE;
          end
        end
        // Wait for the router port to be free and the previous ack to have dropped.
        TX_WAIT_FREE: if (!local_busy_i && !inj.ack) tx_state_q <= TX_REQ;
        TX_REQ:       if (inj.ack) tx_state_q <= TX_RELEASE;
        TX_RELEASE:   if (!inj.ack) tx_state_q <= TX_IDLE;
        default:      tx_state_q <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receive ----------------
  logic        rx_state_q;
  logic [AW:0] wptr_q;
  logic [AW:0] rptr_q;
  br_data_t    mem_q [RX_DEPTH];
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop        = !fifo_empty && rx_ready_i;
  // A full FIFO still takes a flit when a pop frees the slot in the same cycle.
  assign push       = (rx_state_q == RX_IDLE) && dlv.req && (!fifo_full || pop);

  assign rx_valid_o = !fifo_empty;
  assign rx_flit_o  = mem_q[rptr_q[AW-1:0]];
  assign dlv.ack    = (rx_state_q == RX_ACK);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rx_state_q <= RX_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrOne;
      if (pop)  rptr_q <= rptr_q + PtrOne;
      case (rx_state_q)
        RX_IDLE: if (push) rx_state_q <= RX_ACK;
        RX_ACK:  if (!dlv.req) rx_state_q <= RX_IDLE;
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= dlv.flit;
  end

endmodule

// File: tb/tb_br_lite_ni.sv
// Directed bench for br_lite_ni: a transaction-level model (expected flit, id counter, receive
// queue) is compared against the DUT every cycle, alongside hand-computed literal checks.
module tb_br_lite_ni;
  localparam logic [15:0] Addr = 16'h00A7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        tx_tgt = 1'b0;
  logic [15:0] tx_target = '0;
  logic [31:0] tx_payload = '0;
  logic [7:0]  tx_id;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [72:0] rx_flit;
  logic        local_busy = 1'b0;

  br_lite_ni_if inj ();
  br_lite_ni_if dlv ();

  br_lite_ni #(.ADDRESS(Addr), .RX_DEPTH(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready),
    .tx_tgt_i     (tx_tgt),
    .tx_target_i  (tx_target),
    .tx_payload_i (tx_payload),
    .tx_id_o      (tx_id),
    .rx_valid_o   (rx_valid),
    .rx_ready_i   (rx_ready),
    .rx_flit_o    (rx_flit),
    .local_busy_i (local_busy),
    .inj          (inj),
    .dlv          (dlv)
  );

  always #5 clk = ~clk;

  // Router local input: acks within the same cycle req is seen, drops with req.
  always @(negedge clk) inj.ack = inj.req;

  int          n_checks = 0;
  int          n_fail = 0;
  bit          chk_en = 1'b0;
  logic [72:0] model_q[$];
  logic [72:0] exp_flit = '0;
  logic [7:0]  exp_id = '0;
  logic [7:0]  id_model = '0;

  function automatic logic [72:0] mk_flit(input logic [15:0] src, input logic svc,
                                          input logic [15:0] target, input logic [7:0] id,
                                          input logic [31:0] pl);
    return {src, svc ? target : 16'h0000, svc, id, pl};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      check("rx_valid", rx_valid, model_q.size() != 0);
      if (model_q.size() != 0) check("rx_head", rx_flit, model_q[0]);
      check("tx_id", tx_id, exp_id);
      check("flit_o", inj.flit, exp_flit);
      check("req_while_ready", inj.req & tx_ready, 0);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; chk_en = 1'b0;
    tx_valid = 1'b0; rx_ready = 1'b0; local_busy = 1'b0; dlv.req = 1'b0; dlv.flit = '0;
    model_q.delete(); exp_flit = '0; exp_id = '0; id_model = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; chk_en = 1'b1;
  endtask

  // Returns at the negedge right after the accepting posedge.
  task automatic send(input logic tgt, input logic [15:0] target, input logic [31:0] payload);
    int guard = 0;
    @(negedge clk);
    tx_valid = 1'b1; tx_tgt = tgt; tx_target = target; tx_payload = payload;
    while (!tx_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("send_ready", tx_ready, 1);
    if (!tx_ready) begin
      tx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_flit = mk_flit(Addr, tgt, target, id_model, payload);
    exp_id   = id_model;
    id_model = id_model + 8'd1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(output int ncyc, output int nreq);
    ncyc = 0; nreq = 0;
    for (int i = 0; i < 100; i++) begin
      if (inj.req) nreq++;
      ncyc++;
      if (tx_ready) break;
      @(negedge clk);
    end
    check("tx_idle", tx_ready, 1);
  endtask

  task automatic finish_deliver(input logic [72:0] f, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (dlv.ack) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    model_q.push_back(f);
    dlv.req = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!dlv.ack) break;
    end
    check("ack_fall", dlv.ack, 0);
  endtask

  task automatic deliver(input logic [72:0] f, input int bound, output bit ok);
    @(negedge clk);
    dlv.req = 1'b1; dlv.flit = f;
    finish_deliver(f, bound, ok);
  endtask

  task automatic pop_one();
    @(negedge clk);
    rx_ready = 1'b1;
    @(posedge clk);
    if (model_q.size() != 0) void'(model_q.pop_front());
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  logic [72:0] f[5];

  initial begin
    int ncyc, nreq;
    bit ok, ok2;
    dlv.req = 1'b0; dlv.flit = '0;
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_ready", tx_ready, 1);
    check("rst_req", inj.req, 0);
    check("rst_ack", dlv.ack, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_id", tx_id, 0);
    check("rst_flit", inj.flit, 0);

    // Broadcast
    send(1'b0, 16'hFFFF, 32'hA5A5_0001);
    check("bc_flit", inj.flit, {16'h00A7, 16'h0000, 1'b0, 8'h00, 32'hA5A5_0001});
    check("bc_id", tx_id, 0);
    wait_idle(ncyc, nreq);
    check("bc_cycles", ncyc, 4);
    check("bc_req_cycles", nreq, 1);

    // Busy gate
    local_busy = 1'b1;
    send(1'b1, 16'h0033, 32'h0000_BB01);
    for (int i = 0; i < 20; i++) begin
      check("busy_req_low", inj.req, 0);
      if (i < 19) @(negedge clk);
    end
    local_busy = 1'b0;
    @(negedge clk);
    check("busy_req_rise", inj.req, 1);
    check("busy_flit", inj.flit, {16'h00A7, 16'h0033, 1'b1, 8'h01, 32'h0000_BB01});
    wait_idle(ncyc, nreq);

    // Concurrent TX and RX
    fork
      send(1'b1, 16'h0042, 32'hCAFE_0042);
      deliver(mk_flit(16'h0055, 1'b1, 16'h00A7, 8'h09, 32'h1234_5678), 20, ok);
    join
    check("conc_rx_ok", ok, 1);
    wait_idle(ncyc, nreq);
    pop_one();
    check("conc_rx_empty", rx_valid, 0);

    // RX backpressure and simultaneous push/pop when full
    do_reset();
    for (int k = 0; k < 5; k++)
      f[k] = mk_flit(16'h0010 + 16'(k), 1'b1, Addr, 8'(k), 32'h1000_0000 + 32'(k));
    for (int k = 0; k < 4; k++) begin
      deliver(f[k], 20, ok);
      check("bp_acked", ok, 1);
    end
    deliver(f[4], 8, ok);
    check("bp_fifth_blocked", ok, 0);
    check("bp_fifth_ack_low", dlv.ack, 0);
    check("bp_fifth_req_held", dlv.req, 1);
    check("bp_head_first", rx_flit, f[0]);
    fork
      finish_deliver(f[4], 20, ok2);
      pop_one();
    join
    check("bp_fifth_acked", ok2, 1);
    check("simul_head", rx_flit, f[1]);
    check("simul_occupancy", model_q.size(), 4);
    for (int k = 1; k < 5; k++) begin
      check("bp_order", rx_flit, f[k]);
      pop_one();
    end
    check("bp_drained", rx_valid, 0);

    // Id wrap
    do_reset();
    for (int i = 0; i < 257; i++) begin
      send(1'(i), 16'hBEEF ^ 16'(i), 32'(i));
      wait_idle(ncyc, nreq);
    end
    check("wrap_tx_id", tx_id, 0);
    check("wrap_flit_id", inj.flit[39:32], 0);

    // Reset in the middle of TX_REQ
    send(1'b0, 16'h0, 32'h0000_0777);
    wait_idle(ncyc, nreq);
    check("pre_rst_id", tx_id, 1);
    send(1'b0, 16'h0, 32'h0000_0888);
    for (int i = 0; i < 20 && !inj.req; i++) @(negedge clk);
    check("midtx_in_req", inj.req, 1);
    rst_n = 1'b0; chk_en = 1'b0;
    @(negedge clk);
    check("midtx_req", inj.req, 0);
    check("midtx_ready", tx_ready, 1);
    check("midtx_tx_id", tx_id, 0);
    check("midtx_flit", inj.flit, 0);
    model_q.delete(); exp_flit = '0; exp_id = '0; id_model = '0;
    rst_n = 1'b1; chk_en = 1'b1;
    send(1'b1, 16'h0101, 32'h0000_0999);
    check("post_rst_id", tx_id, 0);
    check("post_rst_flit", inj.flit, {16'h00A7, 16'h0101, 1'b1, 8'h00, 32'h0000_0999});
    wait_idle(ncyc, nreq);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/br_lite_ni.md
BR_LITE_NI -- requirements
Module: br_lite_ni

Interface
REQ-001 Parameter ADDRESS, 16'h0000: this PE's router address; inserted as source in every transmitted flit.
REQ-002 Parameter RX_DEPTH, 4: receive FIFO depth in flits; power of two, minimum 2.
REQ-003 clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 rst_ni  input  1  reset; synchronous and active-low.
REQ-005 tx_valid_i  input  1  PE send request.
REQ-006 tx_ready_o  output  1  NI accepts the send this cycle.
REQ-007 tx_tgt_i  input  1  1 = BR_SVC_TGT (targeted), 0 = BR_SVC_ALL (broadcast).
REQ-008 tx_target_i  input  16  target address; used only when tx_tgt_i=1.
REQ-009 tx_payload_i  input  width of br_data_t.payload  payload to send.
REQ-010 tx_id_o  output  width of br_data_t.id  id assigned to the most recently accepted send.
REQ-011 rx_valid_o  input-side output  1  receive FIFO is not empty.
REQ-012 rx_ready_i  input  1  PE pops the head flit.
REQ-013 rx_flit_o  output  br_data_t  head flit of the receive FIFO.
REQ-014 local_busy_i  input  1  router local-port busy flag (pending automatic clear).
REQ-015 flit_o, req_o, ack_i  output/output/input  br_data_t/1/1  injection side, toward router local input.
REQ-016 flit_i, req_i, ack_o  input/input/output  br_data_t/1/1  delivery side, from router local output.

Function
REQ-017 Both router-facing sides SHALL use a 4-phase handshake: req rises, ack rises, req falls, ack falls.
REQ-018 TX FSM states SHALL be TX_IDLE, TX_WAIT_FREE, TX_REQ and TX_RELEASE.
REQ-019 tx_ready_o SHALL be 1 only in TX_IDLE.
REQ-020 On accept (tx_valid_i && tx_ready_o), the block SHALL register flit_o = {source=ADDRESS, target=tx_target_i or 16'h0 for ALL, service, id=id_cnt, payload}, then go to TX_WAIT_FREE.
REQ-021 On accept, tx_id_o SHALL take id_cnt and id_cnt SHALL increment modulo 2^width, wrapping from all-ones to 0.
REQ-022 TX_WAIT_FREE SHALL move to TX_REQ in the first cycle local_busy_i=0 and ack_i=0.
REQ-023 req_o SHALL be 1 only in TX_REQ; on ack_i=1 the FSM SHALL go to TX_RELEASE.
REQ-024 TX_RELEASE SHALL hold req_o=0 and return to TX_IDLE on ack_i=0.
REQ-025 flit_o SHALL stay stable from accept until leaving TX_RELEASE.
REQ-026 Minimum accept-to-next-accept spacing SHALL be 4 cycles when local_busy_i=0 and the router acks in 1 cycle.
REQ-027 RX FSM states SHALL be RX_IDLE and RX_ACK.
REQ-028 In RX_IDLE with req_i=1 and FIFO not full, the block SHALL push flit_i and go to RX_ACK.
REQ-029 In RX_IDLE with the FIFO full, the block SHALL not push and not ack; req_i is back-pressured and no flit is lost.
REQ-030 ack_o SHALL be 1 only in RX_ACK; RX_ACK SHALL return to RX_IDLE on req_i=0.
REQ-031 Each handshake SHALL push exactly one flit.
REQ-032 The FIFO SHALL be first-word-fall-through.
REQ-033 Pop SHALL occur on rx_valid_o && rx_ready_i.
REQ-034 On simultaneous push and pop, including when full, the occupancy SHALL be unchanged.
REQ-035 Read and write pointers SHALL wrap modulo RX_DEPTH; full/empty SHALL be distinguished by an extra pointer bit.
REQ-036 TX and RX SHALL be fully independent; concurrent operation SHALL be legal.
REQ-037 The block SHALL pass received flits unfiltered; service interpretation belongs to the PE.

Reset
REQ-038 While rst_ni=0 at a clock edge, the block SHALL be in TX_IDLE and RX_IDLE, with FIFO empty, id_cnt=0, tx_id_o=0, req_o=0, ack_o=0, rx_valid_o=0, tx_ready_o=1 after release and flit_o=0.
REQ-039 Reset mid-handshake SHALL abandon the transfer with no replay; the integrator resets the router together with this block.

Verification
REQ-040 Broadcast: reset, accept ALL with payload 32'hA5A5_0001, router acks 1 cycle after req -> flit_o.service=BR_SVC_ALL, source=ADDRESS, id=0; req_o high exactly 1 cycle; tx_ready_o back after 4 cycles; tx_id_o=0.
REQ-041 Busy gate: local_busy_i=1 for 20 cycles during an accept -> req_o stays 0 for those 20 cycles and rises the first cycle after local_busy_i falls.
REQ-042 Id wrap: 2^idwidth+1 sends -> final flit id=0 and tx_id_o sequence 0..max,0.
REQ-043 RX backpressure: RX_DEPTH=4, rx_ready_i=0, router offers 5 flits -> 4 acked in order, 5th req_i held with ack_o=0; one pop -> 5th acked; pop order matches arrival.
REQ-044 Simultaneous: FIFO full with push and pop in the same cycle -> occupancy stays 4 and rx_flit_o advances by one.
REQ-045 Reset mid-TX: rst_ni=0 while in TX_REQ -> req_o=0 and tx_ready_o=1 next cycle, id_cnt=0.
